// File: rtl/seq_multiplier_pkg.sv
// rtl/seq_multiplier_pkg.sv - shared state encoding and iteration count for seq_multiplier
package seq_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mulStateT;

    localparam int ITERATIONS = 32;
    localparam logic [5:0] LAST_ITER = 6'(ITERATIONS - 1);

endpackage

// File: rtl/seq_multiplier_adder.sv
// rtl/seq_multiplier_adder.sv - 32-bit ripple-carry adder used by the shift-add datapath
module seq_multiplier_adder (
    input  logic [31:0] DataA,
    input  logic [31:0] DataB,
    output logic [31:0] RAdd,
    output logic        CarryOut
);

    logic [32:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < 32; i++) begin : gRipple
        assign RAdd[i]      = DataA[i] ^ DataB[i] ^ carry[i];
        assign carry[i + 1] = (DataA[i] & DataB[i]) | (carry[i] & (DataA[i] ^ DataB[i]));
    end

    assign CarryOut = carry[32];

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - 32x32 shift-add sequential multiplier, fixed 33-cycle latency
// Define MUL_SIGNED_EN to add the Signed input and signed (sign-magnitude) multiplication.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     DataA,
    input  logic [WIDTH-1:0]     DataB,
`ifdef MUL_SIGNED_EN
    input  logic                 Signed,
`endif
    output logic                 Ready,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product
);

    mulStateT    state;
    mulStateT    nextState;
    logic [5:0]  counter;
    logic [63:0] acc;
    logic [31:0] aReg;
    logic        doneReg;
    logic [63:0] productReg;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] addend;
    logic [31:0] sum;
    logic        sumCarry;
    logic [63:0] result;

`ifdef MUL_SIGNED_EN
    logic negReg;

    // Magnitudes taken at acceptance; -2^31 maps to 32'h80000000, which is 2^31 unsigned.
    assign opA    = (Signed && DataA[31]) ? -DataA : DataA;
    assign opB    = (Signed && DataB[31]) ? -DataB : DataB;
    assign result = negReg ? -acc : acc;
`else
    assign opA    = DataA;
    assign opB    = DataB;
    assign result = acc;
`endif

    assign addend = acc[0] ? aReg : 32'd0;

    seq_multiplier_adder uAdder (
        .DataA    (acc[63:32]),
        .DataB    (addend),
        .RAdd     (sum),
        .CarryOut (sumCarry)
    );

    always_comb begin
        nextState = state;
        Ready     = 1'b0;
        Busy      = 1'b0;
        case (state)
            IDLE: begin
                Ready = 1'b1;
                if (Start) nextState = RUN;
            end
            RUN: begin
                Busy = 1'b1;
                if (counter == LAST_ITER) nextState = DONE;
            end
            DONE: begin
                Busy = 1'b1;
                // First DONE cycle publishes Product; the second, with Done high, exits.
                if (doneReg) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            counter    <= 6'd0;
            acc        <= 64'd0;
            aReg       <= 32'd0;
            doneReg    <= 1'b0;
            productReg <= 64'd0;
`ifdef MUL_SIGNED_EN
            negReg     <= 1'b0;
`endif
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (Start) begin
                        acc     <= {32'd0, opB};
                        aReg    <= opA;
                        counter <= 6'd0;
`ifdef MUL_SIGNED_EN
                        negReg  <= Signed & (DataA[31] ^ DataB[31]);
`endif
                    end
                end
                RUN: begin
                    acc     <= {sumCarry, sum, acc[31:1]};
                    counter <= counter + 6'd1;
                end
                DONE: begin
                    if (!doneReg) begin
                        productReg <= result;
                        doneReg    <= 1'b1;
                    end else begin
                        doneReg    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Done    = doneReg;
    assign Product = productReg;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed self-checking bench for seq_multiplier
module tb_seq_multiplier;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [31:0] DataA;
    logic [31:0] DataB;
`ifdef MUL_SIGNED_EN
    logic        Signed;
`endif
    logic        Ready;
    logic        Busy;
    logic        Done;
    logic [63:0] Product;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] exp;
    } vecT;

    vecT vecs[$];

    always #5 Clk = ~Clk;

    seq_multiplier #(.WIDTH(32)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .DataA   (DataA),
        .DataB   (DataB),
`ifdef MUL_SIGNED_EN
        .Signed  (Signed),
`endif
        .Ready   (Ready),
        .Busy    (Busy),
        .Done    (Done),
        .Product (Product)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Returns at the negedge following the accepting edge; operands are scrambled afterwards.
    task automatic startOp(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        @(negedge Clk);
        DataA = a;
        DataB = b;
`ifdef MUL_SIGNED_EN
        Signed = sgn;
`else
        if (sgn) $display("signed vector skipped in unsigned build");
`endif
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        DataA = ~a;
        DataB = b ^ 32'h5A5A_A5A5;
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        while (!Done && lat < 40) begin
            @(negedge Clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int holdBad;
        int sawDone;

        vecs.push_back('{32'd3,          32'd5,          1'b0, 64'd15});
        vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001});
        vecs.push_back('{32'h0001_0000,  32'h0001_0000,  1'b0, 64'h0000_0001_0000_0000});
        vecs.push_back('{32'hDEAD_BEEF,  32'd1,          1'b0, 64'h0000_0000_DEAD_BEEF});
        vecs.push_back('{32'h1234_5678,  32'd0,          1'b0, 64'd0});
        vecs.push_back('{32'h8000_0000,  32'd2,          1'b0, 64'h0000_0001_0000_0000});
`ifdef MUL_SIGNED_EN
        vecs.push_back('{32'hFFFF_FFFD,  32'd5,          1'b1, 64'hFFFF_FFFF_FFFF_FFF1});
        vecs.push_back('{32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000});
        vecs.push_back('{32'hFFFF_FFF9,  32'hFFFF_FFFA,  1'b1, 64'd42});
        vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001});
        Signed = 1'b0;
`endif

        Reset = 1'b1;
        Start = 1'b0;
        DataA = 32'd0;
        DataB = 32'd0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("reset_ready",   64'(Ready),   64'd1);
        check("reset_busy",    64'(Busy),    64'd0);
        check("reset_done",    64'(Done),    64'd0);
        check("reset_product", Product,      64'd0);

        foreach (vecs[i]) begin
            startOp(vecs[i].a, vecs[i].b, vecs[i].sgn);
            check($sformatf("v%0d_busy", i),  64'(Busy),  64'd1);
            check($sformatf("v%0d_ready", i), 64'(Ready), 64'd0);
            waitDone(lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd33);
            check($sformatf("v%0d_product", i), Product,  vecs[i].exp);
            @(negedge Clk);
            check($sformatf("v%0d_ready_after", i), 64'(Ready), 64'd1);
            check($sformatf("v%0d_done_pulse", i),  64'(Done),  64'd0);
        end

        // Zero operand, Start pulse and operand change mid-RUN.
        startOp(32'd0, 32'h1234_5678, 1'b0);
        lat = 0;
        while (!Done && lat < 40) begin
            if (lat == 5) begin
                DataA = 32'd5;
                DataB = 32'd5;
                Start = 1'b1;
            end else begin
                Start = 1'b0;
            end
            if (lat == 12) DataA = 32'hFFFF_FFFF;
            @(negedge Clk);
            lat++;
        end
        Start = 1'b0;
        check("zero_latency", 64'(lat), 64'd33);
        check("zero_product", Product,  64'd0);
        sawDone = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done || Busy) sawDone++;
        end
        check("no_queued_op", 64'(sawDone), 64'd0);

        // Back-to-back: 42 must hold throughout the second run.
        startOp(32'd7, 32'd6, 1'b0);
        waitDone(lat);
        check("b2b_first", Product, 64'd42);
        startOp(32'd9, 32'd9, 1'b0);
        holdBad = 0;
        lat = 0;
        while (!Done && lat < 40) begin
            if (Product !== 64'd42) holdBad++;
            @(negedge Clk);
            lat++;
        end
        check("b2b_hold",    64'(holdBad), 64'd0);
        check("b2b_latency", 64'(lat),     64'd33);
        check("b2b_second",  Product,      64'd81);

        // Reset in the middle of a run.
        startOp(32'd3, 32'd5, 1'b0);
        repeat (10) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("midrst_ready",   64'(Ready), 64'd1);
        check("midrst_busy",    64'(Busy),  64'd0);
        check("midrst_done",    64'(Done),  64'd0);
        check("midrst_product", Product,    64'd0);
        sawDone = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done) sawDone++;
        end
        check("midrst_no_done", 64'(sawDone), 64'd0);

        // Start coincident with Reset is dropped.
        @(negedge Clk);
        DataA = 32'd3;
        DataB = 32'd3;
        Reset = 1'b1;
        Start = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        Start = 1'b0;
        check("rst_start_busy", 64'(Busy), 64'd0);
        @(negedge Clk);
        check("rst_start_idle", 64'(Ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter: WIDTH, 32, operand width; only 32 is supported.
REQ-002 Clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request to begin a multiply; SHALL be accepted only when Ready=1.
REQ-005 DataA  input  32  multiplicand; SHALL be sampled on the accepting edge only.
REQ-006 DataB  input  32  multiplier; SHALL be sampled on the accepting edge only.
REQ-007 Ready  output  1  high only in IDLE.
REQ-008 Busy  output  1  high in RUN and DONE.
REQ-009 Done  output  1  one-cycle pulse; Product is valid in the same cycle.
REQ-010 Product  output  64  last completed result; SHALL be held until the next Done.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-012 IDLE->RUN on Start=1, which SHALL:
- load the accumulator to {32'b0, DataB};
- latch DataA;
- clear the 6-bit cycle counter.
REQ-013 Each RUN cycle SHALL:
- compute sum={carry,upper} = upper + (acc[0] ? A : 0);
- shift {carry, upper, lower} right by 1 into the accumulator;
- increment the counter.
REQ-014 RUN->DONE SHALL occur on the edge that completes the 32nd iteration (counter==31).
REQ-015 In DONE the block SHALL register the accumulator into Product, pulse Done for exactly 1 cycle, then return to IDLE.
REQ-016 Latency: Start sampled at edge N -> Done=1 and the new Product visible in the cycle after edge N+33; Ready=1 again after edge N+34.
REQ-017 Start while RUN or DONE SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-018 DataA/DataB changes after acceptance SHALL NOT affect the result.
REQ-019 Product SHALL remain stable throughout a subsequent RUN until that run's DONE.
REQ-020 Unsigned result SHALL equal DataA*DataB exactly in 64 bits; no overflow is possible.
REQ-021 Operand zero SHALL NOT shorten latency; latency is fixed at 33 cycles.

Reset
REQ-022 Reset=1 SHALL force, on the next edge, regardless of state (including mid-RUN):
- state=IDLE;
- Product=0, Done=0, Busy=0, Ready=1;
- counter=0, accumulator=0.
REQ-023 Start asserted in the same cycle as Reset SHALL be ignored.

Configuration
REQ-024 Macro MUL_SIGNED_EN SHALL control signed multiplication.
REQ-025 With MUL_SIGNED_EN defined:
- an extra input port Signed (1 bit) SHALL be sampled with Start;
- when Signed=1, operands SHALL be converted to magnitudes at acceptance and the result sign flag latched as A[31]^B[31];
- the magnitude product SHALL be two's-complement negated when registered into Product if the flag=1;
- -2^31 SHALL be handled as magnitude 2^31;
- latency SHALL be unchanged.
REQ-026 Without MUL_SIGNED_EN: no Signed port; unsigned only; no negation logic is present.

Structure
REQ-027 The shared package SHALL hold:
- the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
- the iteration count constant (32).
REQ-028 The per-cycle addition SHALL use one sub-module: the team's 32-bit ripple Adder (DataA, DataB -> RAdd, CarryOut), instantiated once; its CarryOut feeds the shift-in bit.
REQ-029 Control (FSM, counter) and datapath (accumulator, A register, Product register) SHALL live in seq_multiplier itself.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset, then A=3, B=5, Start for 1 cycle -> Done exactly 33 cycles later, Product=64'd15, Ready back the next cycle.
- A=32'hFFFFFFFF, B=32'hFFFFFFFF -> Product=64'hFFFFFFFE00000001.
- A=0, B=32'h12345678 -> Product=0 after the full 33 cycles; Start pulsed mid-RUN is ignored; DataA changed mid-RUN has no effect.
- Two back-to-back ops, 7*6 then 9*9 -> Product holds 42 until the second Done, then reads 81.
- Reset asserted at RUN cycle 10 -> next cycle IDLE, Ready=1, Product=0, no Done pulse.
- MUL_SIGNED_EN, Signed=1: -3*5 -> 64'hFFFFFFFFFFFFFFF1; 32'h80000000*32'h80000000 -> 64'h4000000000000000.
